f2i_pipe: RTL and testbench

Pipelined, parametrised float-to-integer converter for the processor's custom float format (sign, two's-complement exponent, unnormalised magnitude mantissa; value = (-1)^s · m · 2^e). It sits between the float register path and the integer datapath.

Compared with the single-cycle converter, it adds:
- an independent output width;
- saturation with an overflow flag;
- an inexact flag;
- valid/ready flow control;
- a correct result for the most-negative exponent;
- optional round-to-nearest.

---
 rtl/f2i_pipe.sv | 158 +++++++++++++++
 tb/tb_f2i_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/f2i_pipe.sv
// Three-stage float-to-integer converter (value = (-1)^s * m * 2^e) with saturation,
// inexact flag and valid/ready flow control. Define F2I_ROUND_EN for round-to-nearest, ties away.
module f2i_pipe #(
   parameter int MAN    = 23,
   parameter int EXP    = 8,
   parameter int NUBITS = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [MAN+EXP:0]   in,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [NUBITS-1:0]  out,
   output logic               ovf,
   output logic               inx
);

   localparam int STAGES = 3;
   localparam int BLW    = $clog2(MAN+1);
   localparam int SW0    = (EXP > BLW) ? EXP : BLW;
   localparam int SW1    = ($clog2(NUBITS+1) > SW0) ? $clog2(NUBITS+1) : SW0;
   localparam int SW     = SW1 + 2;
   localparam int MW     = NUBITS + 1;
   localparam int RW     = NUBITS + 2;
   localparam logic [EXP:0]    RMAX = (EXP+1)'(MAN+1);
   localparam logic [RW-1:0]   NLIM = RW'(1) << (NUBITS-1);
   localparam logic [RW-1:0]   PLIM = NLIM - RW'(1);

   logic              en;
   logic [STAGES:1]   vld_pipe;

   assign en      = !out_vld || out_rdy;
   assign in_rdy  = en;
   assign out_vld = vld_pipe[STAGES];

   always_ff @(posedge clk) begin
      if (rst)     vld_pipe <= '0;
      else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_vld};
   end

   // ---------------- stage 1: unpack ----------------
   logic            in_s;
   logic [EXP-1:0]  in_e;
   logic [MAN-1:0]  in_m;
   logic [BLW-1:0]  blen;
   logic            lov_c;
   logic [EXP:0]    rsh_c;

   assign in_s = in[MAN+EXP];
   assign in_e = in[MAN+EXP-1:MAN];
   assign in_m = in[MAN-1:0];

   always_comb begin
      blen = '0;
      for (int i = 0; i < MAN; i++)
         if (in_m[i]) blen = BLW'(i+1);
   end

   assign lov_c = (in_m != '0) && !in_e[EXP-1] &&
                  ((SW'(blen) + SW'(in_e[EXP-2:0])) > SW'(NUBITS));
   // EXP+1 bits so the most-negative exponent negates without wrapping
   assign rsh_c = (EXP+1)'(0) - {in_e[EXP-1], in_e};

   logic            s1_s, s1_neg, s1_lov;
   logic [MAN-1:0]  s1_m;
   logic [EXP-2:0]  s1_l;
   logic [EXP:0]    s1_r;

   always_ff @(posedge clk) begin
      if (en) begin
         s1_s   <= in_s;
         s1_m   <= in_m;
         s1_neg <= in_e[EXP-1];
         s1_l   <= in_e[EXP-2:0];
         s1_r   <= rsh_c;
         s1_lov <= lov_c;
      end
   end

   // ---------------- stage 2: shift ----------------
   logic [MW-1:0]   mag_l;
   logic [2*MAN:0]  rt;
   logic [MW-1:0]   mag_c;
   logic            g_c, st_c;

   assign mag_l = MW'(s1_m) << s1_l;
   assign rt    = {s1_m, {(MAN+1){1'b0}}} >> s1_r;

   always_comb begin
      mag_c = mag_l;
      g_c   = 1'b0;
      st_c  = 1'b0;
      if (s1_neg) begin
         mag_c = MW'(rt[2*MAN:MAN+1]);
         g_c   = rt[MAN];
         // beyond MAN+1 every mantissa bit falls below the guard position
         st_c  = (s1_r > RMAX) ? (|s1_m) : (|rt[MAN-1:0]);
      end
   end

   logic            s2_s, s2_g, s2_st, s2_lov, s2_zero;
   logic [MW-1:0]   s2_mag;

   always_ff @(posedge clk) begin
      if (en) begin
         s2_s    <= s1_s;
         s2_mag  <= mag_c;
         s2_g    <= g_c;
         s2_st   <= st_c;
         s2_lov  <= s1_lov;
         s2_zero <= (s1_m == '0);
      end
   end

   // ---------------- stage 3: round, sign, saturate ----------------
   logic              inx_c, inc, sat;
   logic [RW-1:0]     rmag;
   logic [NUBITS-1:0] res;
   logic              res_ovf, res_inx;

   assign inx_c = s2_g | s2_st;
`ifdef F2I_ROUND_EN
   assign inc = s2_g;
`else
   assign inc = s2_s & inx_c;
`endif
   assign rmag = RW'(s2_mag) + RW'(inc);
   assign sat  = s2_lov || (rmag > (s2_s ? NLIM : PLIM));

   always_comb begin
      res     = s2_s ? NUBITS'(-rmag) : NUBITS'(rmag);
      res_ovf = 1'b0;
      res_inx = inx_c;
      if (s2_zero) begin
         res     = '0;
         res_inx = 1'b0;
      end else if (sat) begin
         res     = s2_s ? {1'b1, {(NUBITS-1){1'b0}}} : {1'b0, {(NUBITS-1){1'b1}}};
         res_ovf = 1'b1;
         res_inx = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out <= '0;
         ovf <= 1'b0;
         inx <= 1'b0;
      end else if (en && vld_pipe[STAGES-1]) begin
         out <= res;
         ovf <= res_ovf;
         inx <= res_inx;
      end
   end

endmodule

// File: tb/tb_f2i_pipe.sv
// Directed bench for f2i_pipe: conversion vectors, saturation and exponent boundaries,
// backpressure hold/ordering and mid-stream reset.
module tb_f2i_pipe;
   localparam int MAN = 23, EXP = 8, NB = 32;
`ifdef F2I_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, in_vld, in_rdy, out_vld, out_rdy, ovf, inx;
   logic [MAN+EXP:0] din;
   logic [NB-1:0]    dout;
   int n_tests = 0, n_fail = 0;

   f2i_pipe #(.MAN(MAN), .EXP(EXP), .NUBITS(NB)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in(din),
      .out_vld(out_vld), .out_rdy(out_rdy), .out(dout), .ovf(ovf), .inx(inx)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] fw(input logic s, input logic [7:0] e, input logic [22:0] m);
      return {s, e, m};
   endfunction

   // one isolated word: checks 3-edge latency and the result fields
   task automatic conv(input string tag, input logic s, input logic [7:0] e, input logic [22:0] m,
                       input logic [31:0] eo, input logic eovf, input logic einx);
      out_rdy = 1'b1;
      in_vld  = 1'b1;
      din     = fw(s, e, m);
      #1;
      chk({tag, ".in_rdy"}, 32'(in_rdy), 32'd1);
      step();
      in_vld = 1'b0;
      din    = '0;
      step();
      chk({tag, ".early"}, 32'(out_vld), 32'd0);
      step();
      chk({tag, ".vld"}, 32'(out_vld), 32'd1);
      chk({tag, ".out"}, dout, eo);
      chk({tag, ".ovf"}, 32'(ovf), 32'(eovf));
      chk({tag, ".inx"}, 32'(inx), 32'(einx));
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int tx, rx, stall;
   bit seen, acc;
   logic [31:0] held;

   initial begin
      rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; din = '0;
      step(); step();
      chk("rst.out_vld", 32'(out_vld), 32'd0);
      chk("rst.out", dout, 32'd0);
      chk("rst.ovf", 32'(ovf), 32'd0);
      chk("rst.inx", 32'(inx), 32'd0);
      rst = 1'b0; out_rdy = 1'b1;
      #1;
      chk("rst.in_rdy", 32'(in_rdy), 32'd1);

      conv("basic",   1'b0, 8'd3,   23'd5,       32'd40,                          1'b0, 1'b0);
      conv("frac",    1'b1, 8'hFE,  23'd5,       RND ? 32'hFFFFFFFF : 32'hFFFFFFFE, 1'b0, 1'b1);
      conv("half",    1'b0, 8'hFF,  23'd3,       RND ? 32'd2 : 32'd1,             1'b0, 1'b1);
      conv("sat_p9",  1'b0, 8'd9,   23'h7FFFFF,  32'h7FFFFFFF,                    1'b1, 1'b0);
      conv("neg_e8",  1'b1, 8'd8,   23'h7FFFFF,  32'h80000100,                    1'b0, 1'b0);
      conv("neg_min", 1'b1, 8'd31,  23'd1,       32'h80000000,                    1'b0, 1'b0);
      conv("pos_31",  1'b0, 8'd31,  23'd1,       32'h7FFFFFFF,                    1'b1, 1'b0);
      conv("lov_n32", 1'b1, 8'd32,  23'd1,       32'h80000000,                    1'b1, 1'b0);
      conv("emin",    1'b1, 8'h80,  23'h7FFFFF,  RND ? 32'd0 : 32'hFFFFFFFF,      1'b0, 1'b1);
      conv("emin_m0", 1'b0, 8'h80,  23'd0,       32'd0,                           1'b0, 1'b0);
      conv("m0_neg",  1'b1, 8'd5,   23'd0,       32'd0,                           1'b0, 1'b0);
      conv("r24",     1'b0, 8'hE8,  23'h7FFFFF,  32'd0,                           1'b0, 1'b1);
      conv("tie23",   1'b0, 8'hE9,  23'h400000,  RND ? 32'd1 : 32'd0,             1'b0, 1'b1);

      // backpressure: 6 words back-to-back, out_rdy low 5 cycles after first result
      tx = 0; rx = 0; stall = 0; seen = 1'b0; held = '0;
      out_rdy = 1'b1; in_vld = 1'b1; din = fw(1'b0, 8'd0, 23'd10);
      for (int c = 0; c < 40 && rx < 6; c++) begin
         if (out_vld && !seen) begin
            seen = 1'b1; stall = 5; held = dout;
         end
         out_rdy = (stall == 0);
         #1;
         if (stall > 0) begin
            chk("bp.hold_out", dout, held);
            chk("bp.hold_vld", 32'(out_vld), 32'd1);
            chk("bp.in_rdy", 32'(in_rdy), 32'd0);
            stall--;
         end
         if (out_vld && out_rdy) begin
            chk("bp.order", dout, 32'(10 * (rx + 1)));
            rx++;
         end
         acc = in_vld && in_rdy;
         step();
         if (acc) tx++;
         in_vld = (tx < 6);
         din    = (tx < 6) ? fw(1'b0, 8'd0, 23'(10 * (tx + 1))) : '0;
      end
      chk("bp.received", 32'(rx), 32'd6);
      chk("bp.sent", 32'(tx), 32'd6);
      chk("bp.no_dup", 32'(out_vld), 32'd0);

      // reset with words in flight; third word coincides with reset and is dropped
      out_rdy = 1'b1;
      in_vld = 1'b1; din = fw(1'b0, 8'd0, 23'd7);
      step();
      din = fw(1'b0, 8'd0, 23'd8);
      step();
      din = fw(1'b1, 8'hFE, 23'd9);
      rst = 1'b1;
      step();
      rst = 1'b0; in_vld = 1'b0; din = '0;
      chk("mrst.out_vld", 32'(out_vld), 32'd0);
      chk("mrst.out", dout, 32'd0);
      chk("mrst.ovf", 32'(ovf), 32'd0);
      chk("mrst.inx", 32'(inx), 32'd0);
      chk("mrst.in_rdy", 32'(in_rdy), 32'd1);
      for (int c = 0; c < 4; c++) begin
         chk("mrst.drained", 32'(out_vld), 32'd0);
         step();
      end
      conv("post_rst", 1'b0, 8'd1, 23'd3, 32'd6, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
